// File: rtl/uart_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed UART frame into instruction memory
// and releases the CPU from reset once the frame is accepted.
module uart_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_rst_n
);

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_SUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_WIDTH;

   state_t              state;
   state_t              state_next;
   logic [15:0]         len;
   logic [ADDR_WIDTH:0] word_idx;
   logic [1:0]          byte_idx;
   logic [23:0]         shift;
   logic [7:0]          xor_acc;
   logic [15:0]         len_full;
   logic                last_word;
   logic                word_wr;

   assign len_full  = {rx_data, len[7:0]};
   assign last_word = (33'(word_idx) + 33'd1) == 33'(len);

   always_comb begin
      state_next = state;
      word_wr    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_LEN0: begin
            busy = 1'b1;
            if (rx_valid) state_next = S_LEN1;
         end
         S_LEN1: begin
            busy = 1'b1;
            if (rx_valid) begin
               if (33'(len_full) > MAX_LEN) state_next = S_ERR;
               else if (len_full == 16'd0)  state_next = S_SUM;
               else                         state_next = S_DATA;
            end
         end
         S_DATA: begin
            busy = 1'b1;
            if (rx_valid && byte_idx == 2'd3) begin
               word_wr = 1'b1;
               if (last_word) state_next = S_SUM;
            end
         end
         S_SUM: begin
            busy = 1'b1;
            if (rx_valid) state_next = (rx_data == xor_acc) ? S_DONE : S_ERR;
         end
         S_DONE:  done  = 1'b1;
         S_ERR:   error = 1'b1;
         default: state_next = S_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_LEN0;
         len        <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         shift      <= '0;
         xor_acc    <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
      end else begin
         state     <= state_next;
         imem_we   <= word_wr;
         cpu_rst_n <= (state_next == S_DONE);
         // The checksum covers every byte before SUM, length bytes included.
         if (rx_valid && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
            xor_acc <= xor_acc ^ rx_data;
         if (rx_valid && state == S_LEN0) len[7:0]  <= rx_data;
         if (rx_valid && state == S_LEN1) len[15:8] <= rx_data;
         if (rx_valid && state == S_DATA) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               imem_addr  <= word_idx[ADDR_WIDTH-1:0];
               imem_wdata <= {rx_data, shift};
               word_idx   <= word_idx + 1'b1;
            end else begin
               shift <= {rx_data, shift[23:8]};
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table vectors, hand-written corner sequences and random frames
// checked against a frame-level reference model.
module tb_uart_loader;

   localparam int AW   = 4;
   localparam int MAXN = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic          cpu_rst_n;

   uart_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            t;
   } wr_t;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int         nb;
      logic [7:0] by[16];
      logic       exp_done;
      logic       exp_err;
      int         exp_nw;
   } vec_t;

   wr_t wq[$];
   always @(negedge clk) if (rst_n && imem_we) wq.push_back('{imem_addr, imem_wdata, cyc});

   int  checks = 0;
   int  errors = 0;
   wr_t exp_wq[$];
   bit  exp_done;
   bit  exp_err;
   int  exp_term;
   int  dt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctrl"}, 32'({imem_we, busy, done, error, cpu_rst_n}), 32'b01000);
      check({tag, "_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_wdata"}, imem_wdata, 32'd0);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
   endtask

   // Frame-level model: word count, checksum and over-length rules applied to the byte list.
   task automatic model(input bq_t b);
      int   n;
      logic [7:0] x;
      exp_wq.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      n = int'({b[1], b[0]});
      if (n > MAXN) begin
         exp_err  = 1'b1;
         exp_term = 1;
      end else begin
         for (int w = 0; w < n; w++)
            if (b.size() >= 2 + 4 * w + 4)
               exp_wq.push_back('{AW'(w), {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]}, 2 + 4 * w + 3});
         exp_term = 2 + 4 * n;
         x = 8'h00;
         for (int i = 0; i < exp_term && i < b.size(); i++) x ^= b[i];
         if (b.size() > exp_term) begin
            exp_done = (b[exp_term] == x);
            exp_err  = !exp_done;
         end
      end
   endtask

   task automatic run_frame(input bq_t b, input int maxgap, input bit rst_first);
      if (rst_first) do_reset();
      model(b);
      dt.delete();
      for (int i = 0; i < b.size(); i++) begin
         if (i == exp_term) check("pre_term_status", 32'({busy, done, error}), 32'b100);
         rx_valid = 1'b1;
         rx_data  = b[i];
         dt.push_back(cyc);
         @(negedge clk);
         rx_valid = 1'b0;
         if (i == exp_term)
            check("term_status", 32'({busy, done, error, cpu_rst_n}), 32'({1'b0, exp_done, exp_err, exp_done}));
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("final_status", 32'({busy, done, error, cpu_rst_n}),
            32'({~(exp_done | exp_err), exp_done, exp_err, exp_done}));
      check("write_count", wq.size(), exp_wq.size());
      for (int k = 0; k < exp_wq.size() && k < wq.size(); k++) begin
         check("write_addr", 32'(wq[k].addr), 32'(exp_wq[k].addr));
         check("write_data", wq[k].data, exp_wq[k].data);
         check("write_time", wq[k].t, dt[exp_wq[k].t] + 1);
      end
   endtask

   vec_t tbl[7];
   bq_t  b;
   int   n;
   logic [7:0] x;

   initial begin
      tbl[0] = '{7,  '{8'h01,8'h00,8'h78,8'h56,8'h34,8'h12,8'h09,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 1};
      tbl[1] = '{3,  '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 0};
      tbl[2] = '{14, '{8'h01,8'h00,8'h78,8'h56,8'h34,8'h12,8'h08,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00}, 1'b0, 1'b1, 1};
      tbl[3] = '{5,  '{8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b1, 0};
      tbl[4] = '{11, '{8'h02,8'h00,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 2};
      tbl[5] = '{2,  '{8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b1, 0};
      tbl[6] = '{9,  '{8'h01,8'h00,8'h78,8'h56,8'h34,8'h12,8'h09,8'h55,8'h66,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 1};

      repeat (2) @(negedge clk);
      check_reset_vals("initial");
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         b.delete();
         for (int j = 0; j < tbl[i].nb; j++) b.push_back(tbl[i].by[j]);
         run_frame(b, 0, 1'b1);
         check("tbl_done", 32'(done), 32'(tbl[i].exp_done));
         check("tbl_error", 32'(error), 32'(tbl[i].exp_err));
         check("tbl_writes", wq.size(), tbl[i].exp_nw);
      end

      // Known word for the single-word frame.
      b = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      run_frame(b, 0, 1'b1);
      check("n1_data", wq[0].data, 32'h12345678);

      // Back-to-back two-word frame: writes exactly four cycles apart.
      b = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h02};
      run_frame(b, 0, 1'b1);
      check("b2b_w0", wq[0].data, 32'h03020100);
      check("b2b_w1", wq[1].data, 32'h07060504);
      check("b2b_spacing", wq[1].t - wq[0].t, 4);

      // Largest legal frame, good then bad checksum.
      for (int bad = 0; bad < 2; bad++) begin
         b = '{8'h10, 8'h00};
         x = 8'h10;
         for (int j = 0; j < 4 * MAXN; j++) begin
            b.push_back(8'(j * 7 + 3));
            x ^= 8'(j * 7 + 3);
         end
         b.push_back(bad != 0 ? ~x : x);
         run_frame(b, 1, 1'b1);
         check("nmax_done", 32'(done), 32'(bad == 0));
         check("nmax_writes", wq.size(), MAXN);
      end

      // Reset mid-frame after one word and three bytes of the next.
      do_reset();
      b = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      foreach (b[i]) begin
         rx_valid = 1'b1;
         rx_data  = b[i];
         @(negedge clk);
      end
      rx_valid = 1'b0;
      @(negedge clk);
      check("midrst_prewrite", wq.size(), 1);
      check("midrst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
      b = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      run_frame(b, 0, 1'b0);
      check("midrst_after_data", wq[0].data, 32'h12345678);

      // Random frames with gaps, corrupted checksums and over-length counts.
      for (int r = 0; r < 40; r++) begin
         b.delete();
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXN + 1, 300) : $urandom_range(0, MAXN);
         b.push_back(8'(n));
         b.push_back(8'(n >> 8));
         x = 8'(n) ^ 8'(n >> 8);
         if (n <= MAXN) begin
            for (int j = 0; j < 4 * n; j++) begin
               b.push_back(8'($urandom));
               x ^= b[b.size() - 1];
            end
            b.push_back(($urandom_range(0, 3) == 0) ? x ^ 8'(1 << $urandom_range(0, 7)) : x);
         end
         repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
         run_frame(b, 2, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader between the UART receiver and instruction memory. Consumes the receiver's byte stream (`uart_re` / `rd_data`) and parses a length-prefixed, XOR-checksummed frame. Assembles little-endian 32-bit words and writes them to consecutive instruction-memory word addresses starting at 0. Holds the CPU in reset until a frame completes with a valid checksum.

## Interface

- `ADDR_WIDTH`, default 14: word-address width of instruction memory; maximum frame length is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle byte strobe from the UART receiver's `uart_re`.
- `rx_data`  in  8  received byte, valid while `rx_valid`=1.
- `imem_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  write data.
- `busy`  out  1  1 while a frame is being parsed.
- `done`  out  1  frame accepted; sticky until reset.
- `error`  out  1  frame rejected; sticky until reset.
- `cpu_rst_n`  out  1  CPU reset, active-low; released only on `done`.

## Operation

- Frame format, in byte order:
  - LEN0: low byte of N.
  - LEN1: high byte of N. N is a 16-bit word count.
  - DATA: 4·N data bytes, least-significant byte of each word first.
  - SUM: one checksum byte.
- Checksum rule: SUM must equal the XOR of every preceding frame byte, LEN0 and LEN1 included.
- FSM states: S_LEN0, S_LEN1, S_DATA, S_SUM, S_DONE, S_ERR. Reset state is S_LEN0.
- Each state advances only on `rx_valid`=1; each `rx_valid` consumes exactly one byte.
- S_LEN0: latch the low byte of N → S_LEN1.
- S_LEN1: latch the high byte of N, then:
  - N > 2^ADDR_WIDTH → S_ERR.
  - N = 0 → S_SUM.
  - Otherwise → S_DATA.
- S_DATA: a 2-bit byte index selects the byte lane. A 4-byte shift register assembles the word. On the 4th byte:
  - Issue a write at the current word index.
  - Increment the word index.
  - After the write of word N-1 → S_SUM.
- S_SUM: byte equals the running XOR → S_DONE; otherwise → S_ERR.
- S_DONE and S_ERR are terminal. `rx_valid` is ignored until `rst_n` is asserted.
- The word index is ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH is representable. `imem_addr` carries its low ADDR_WIDTH bits; no wrap occurs because N is bounded.
- `busy` = 1 in S_LEN0, S_LEN1, S_DATA and S_SUM.
- `done` = 1 in S_DONE. `error` = 1 in S_ERR.
- `cpu_rst_n` is a register: set to 1 on entry to S_DONE, held at 0 otherwise.
- Memory already written by an errored frame is neither cleared nor rolled back.

## Timing

- Reset values of all outputs: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=1, `done`=0, `error`=0, `cpu_rst_n`=0.
- Reset is asynchronous and may be asserted mid-frame. It returns the block to S_LEN0 and clears the word index, byte index and XOR accumulator; any partial word is discarded.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered and valid in the cycle after the `rx_valid` of the word's 4th byte. `imem_we` is high for exactly 1 cycle.
- Between writes, `imem_addr` and `imem_wdata` hold their last values.
- `done`/`cpu_rst_n` (or `error`) rise in the cycle after the `rx_valid` of the SUM byte.
- An over-length N raises `error` in the cycle after the `rx_valid` of LEN1.
- `rx_valid` may be asserted on consecutive cycles. Every byte is consumed with no stall, and back-to-back word writes may occur every 4 cycles.
- No timeout. Gaps of any length between bytes are legal.

## Test plan

- N=1, bytes 01 00 78 56 34 12 09 → one `imem_we` pulse: addr 0, data 0x12345678. Then `done`=1, `cpu_rst_n`=1, `busy`=0, `error`=0.
- N=0, bytes 00 00 00 → no `imem_we` pulse; `done`=1 one cycle after the 3rd byte.
- Same frame as case 1 with SUM=08 → write to addr 0 still occurs. Then `error`=1, `cpu_rst_n` stays 0, and further bytes are ignored.
- ADDR_WIDTH=4, bytes 11 00 (N=17) → `error`=1 one cycle after the 2nd byte, no writes. Bytes 10 00 (N=16) are accepted.
- N=2, all 11 bytes on consecutive cycles (data 00..07, SUM = XOR of all) → writes 0x03020100 to addr 0 and 0x07060504 to addr 1, exactly 4 cycles apart; then `done`=1.
- Assert `rst_n` after 3 data bytes of a frame → all outputs return to reset values. A following valid N=1 frame writes addr 0 correctly and asserts `done`.
